// File: rtl/csr_pkg.sv
// Shared constants for the CSR execute / trap-sequencing stage: CSR addresses,
// Zicsr funct3 encodings, mstatus bit positions and the sequencer state enum.
package csr_pkg;

  localparam int XLEN = 32;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [2:0] OP_RW  = 3'b001;
  localparam logic [2:0] OP_RS  = 3'b010;
  localparam logic [2:0] OP_RC  = 3'b011;
  localparam logic [2:0] OP_RWI = 3'b101;
  localparam logic [2:0] OP_RSI = 3'b110;
  localparam logic [2:0] OP_RCI = 3'b111;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    T_EPC   = 3'd1,
    T_CAUSE = 3'd2,
    T_STAT  = 3'd3,
    M_EPC   = 3'd4,
    M_STAT  = 3'd5,
    M_DONE  = 3'd6
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    logic ok;
    case (op)
      OP_RW, OP_RS, OP_RC, OP_RWI, OP_RSI, OP_RCI: ok = 1'b1;
      default:                                     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/csr_alu.sv
// Zicsr read-modify-write: new CSR value and whether the write is issued.
module csr_alu
  import csr_pkg::*;
#(
  parameter int DATA_W = XLEN
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] old_val,
  input  logic [DATA_W-1:0] operand,
  input  logic              rs1_zero,
  output logic [DATA_W-1:0] new_val,
  output logic              wen
);

  // Set/clear with rs1 (or zimm) of zero must not write, so side effects are skipped.
  always_comb begin
    new_val = old_val;
    wen     = 1'b0;
    case (op)
      OP_RW, OP_RWI: begin
        new_val = operand;
        wen     = 1'b1;
      end
      OP_RS, OP_RSI: begin
        new_val = old_val | operand;
        wen     = !rs1_zero;
      end
      OP_RC, OP_RCI: begin
        new_val = old_val & ~operand;
        wen     = !rs1_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/csr_ctrl.sv
// CSR execute and trap sequencer in front of reg_file's CSR ports: Zicsr RMW
// with old-value writeback, plus ecall entry / mret return CSR sequences and redirect.
module csr_ctrl
  import csr_pkg::*;
#(
  parameter logic [31:0] MCAUSE_ECALL = 32'd11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_valid_pi,
  input  logic [2:0]  csr_op_pi,
  input  logic [11:0] csr_addr_pi,
  input  logic [4:0]  rs1_idx_pi,
  input  logic [31:0] rs1_data_pi,
  input  logic [4:0]  rd_idx_pi,
  input  logic        ecall_pi,
  input  logic        mret_pi,
  input  logic [31:0] pc_pi,
  input  logic [31:0] csr_rdata_pi,
  output logic [11:0] csr_raddr_po,
  output logic        write_csr_po,
  output logic [11:0] csr_waddr_po,
  output logic [31:0] csr_wdata_po,
  output logic        rd_we_po,
  output logic [4:0]  rd_idx_po,
  output logic [31:0] rd_data_po,
  output logic        stall_po,
  output logic        redirect_po,
  output logic [31:0] redirect_pc_po
);

  localparam int DATA_W = XLEN;

  state_t state;

  logic              take_ecall_p0;
  logic              take_mret_p0;
  logic              take_csr_p0;
  logic              is_imm_p0;
  logic              is_rw_p0;
  logic [DATA_W-1:0] operand_p0;
  logic [DATA_W-1:0] alu_new_p0;
  logic              alu_wen_p0;

  logic              vld_p1;
  logic              rd_en_p1;
  logic [4:0]        rd_idx_p1;
  logic [DATA_W-1:0] rd_data_p1;
  logic              wr_en_p1;
  logic [11:0]       wr_addr_p1;
  logic [DATA_W-1:0] wr_data_p1;
  logic              redir_p1;
  logic [DATA_W-1:0] redir_pc_p1;

  logic [DATA_W-1:0] mtvec_lat;
  logic [DATA_W-1:0] mepc_lat;

  function automatic logic [DATA_W-1:0] trap_mstatus(input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] r;
    r           = s;
    r[MPIE_BIT] = s[MIE_BIT];
    r[MIE_BIT]  = 1'b0;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] mret_mstatus(input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] r;
    r           = s;
    r[MIE_BIT]  = s[MPIE_BIT];
    r[MPIE_BIT] = 1'b1;
    return r;
  endfunction

  // ---- p0: accept / decode (IDLE only; ecall > mret > csr_valid) ----
  assign take_ecall_p0 = (state == IDLE) && ecall_pi;
  assign take_mret_p0  = (state == IDLE) && !ecall_pi && mret_pi;
  assign take_csr_p0   = (state == IDLE) && !ecall_pi && !mret_pi && csr_valid_pi
                         && op_legal(csr_op_pi);

  assign is_imm_p0  = csr_op_pi[2];
  assign is_rw_p0   = (csr_op_pi == OP_RW) || (csr_op_pi == OP_RWI);
  assign operand_p0 = is_imm_p0 ? {{(DATA_W-5){1'b0}}, rs1_idx_pi} : rs1_data_pi;

  csr_alu #(.DATA_W(DATA_W)) u_alu (
    .op       (csr_op_pi),
    .old_val  (csr_rdata_pi),
    .operand  (operand_p0),
    .rs1_zero (rs1_idx_pi == 5'd0),
    .new_val  (alu_new_p0),
    .wen      (alu_wen_p0)
  );

  always_comb begin
    csr_raddr_po = '0;
    case (state)
      IDLE:    if (take_csr_p0 || (csr_valid_pi && !ecall_pi && !mret_pi))
                 csr_raddr_po = csr_addr_pi;
      T_EPC:   csr_raddr_po = CSR_MTVEC;
      T_CAUSE: csr_raddr_po = CSR_MSTATUS;
      M_EPC:   csr_raddr_po = CSR_MEPC;
      M_STAT:  csr_raddr_po = CSR_MSTATUS;
      default: csr_raddr_po = '0;
    endcase
  end

  assign stall_po = (state != IDLE) || ecall_pi || mret_pi;

  // ---- p1: registered CSR write / GPR writeback / redirect ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      vld_p1      <= 1'b0;
      rd_en_p1    <= 1'b0;
      rd_idx_p1   <= '0;
      rd_data_p1  <= '0;
      wr_en_p1    <= 1'b0;
      wr_addr_p1  <= '0;
      wr_data_p1  <= '0;
      redir_p1    <= 1'b0;
      redir_pc_p1 <= '0;
    end else begin
      vld_p1   <= 1'b0;
      rd_en_p1 <= 1'b0;
      wr_en_p1 <= 1'b0;
      redir_p1 <= 1'b0;
      case (state)
        IDLE: begin
          if (take_ecall_p0) begin
            state      <= T_EPC;
            wr_en_p1   <= 1'b1;
            wr_addr_p1 <= CSR_MEPC;
            wr_data_p1 <= pc_pi & ~32'd3;
          end else if (take_mret_p0) begin
            state <= M_EPC;
          end else if (take_csr_p0) begin
            vld_p1     <= 1'b1;
            rd_en_p1   <= !(is_rw_p0 && (rd_idx_pi == 5'd0));
            rd_idx_p1  <= rd_idx_pi;
            rd_data_p1 <= csr_rdata_pi;
            wr_en_p1   <= alu_wen_p0;
            wr_addr_p1 <= csr_addr_pi;
            wr_data_p1 <= alu_new_p0;
          end
        end
        T_EPC: begin
          state      <= T_CAUSE;
          wr_en_p1   <= 1'b1;
          wr_addr_p1 <= CSR_MCAUSE;
          wr_data_p1 <= MCAUSE_ECALL;
        end
        T_CAUSE: begin
          state       <= T_STAT;
          wr_en_p1    <= 1'b1;
          wr_addr_p1  <= CSR_MSTATUS;
          wr_data_p1  <= trap_mstatus(csr_rdata_pi);
          redir_p1    <= 1'b1;
          redir_pc_p1 <= mtvec_lat & ~32'd3;
        end
        M_EPC: begin
          state <= M_STAT;
        end
        M_STAT: begin
          state       <= M_DONE;
          wr_en_p1    <= 1'b1;
          wr_addr_p1  <= CSR_MSTATUS;
          wr_data_p1  <= mret_mstatus(csr_rdata_pi);
          redir_p1    <= 1'b1;
          redir_pc_p1 <= mepc_lat;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Trap operands are plain data; they are always rewritten before use.
  always_ff @(posedge clk) begin
    if (state == T_EPC) mtvec_lat <= csr_rdata_pi;
    if (state == M_EPC) mepc_lat  <= csr_rdata_pi;
  end

  assign write_csr_po   = wr_en_p1;
  assign csr_waddr_po   = wr_addr_p1;
  assign csr_wdata_po   = wr_data_p1;
  assign rd_we_po       = vld_p1 && rd_en_p1;
  assign rd_idx_po      = rd_idx_p1;
  assign rd_data_po     = rd_data_p1;
  assign redirect_po    = redir_p1;
  assign redirect_pc_po = redir_pc_p1;

endmodule
